// File: rtl/enc_mpp_suffix_pack.sv
// Encoder MPP suffix packer: packs 12 offset-biased residual codes into a left-aligned 128-bit suffix.
// Latency: out_valid rises in the cycle after the edge that accepts beat 2; output held until taken.
// Backpressure: in_ready drops while a packed block is held; nothing is accepted until out_ready takes it.
//
// Ports: clk/rst (sync, active-high); bitDepth/stepSize (sampled on beat 0);
//        in_valid/in_ready/in_res (4 signed 8-bit residuals per beat, sample 0 in the MSBs);
//        out_valid/out_ready/suffix/qres_size/out_err (packed block to the substream bit writer).
module enc_mpp_suffix_pack #(
  parameter int ssm_idx = 0,
  parameter int comp    = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   bitDepth,
  input  logic [3:0]   stepSize,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] suffix,
  output logic [7:0]   qres_size,
  output logic         out_err
);

  typedef enum logic [1:0] {
    G0   = 2'd0,
    G1   = 2'd1,
    G2   = 2'd2,
    FULL = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     bits_q;
  logic [127:0]   acc_q;
  logic           flag_q;

  logic           beat_xfer, blk_xfer;
  logic [3:0]     raw_bits, cur_bits;
  logic           raw_bad;
  logic [1:0]     grp;
  logic [8:0]     half;
  logic signed [8:0] hi_s, lo_s, res_s, sat_s;
  logic [8:0]     code9;
  logic [7:0]     code_al;
  logic [7:0]     k_idx, shift;
  logic [127:0]   place;
  logic           clamp_any;
  logic [127:0]   acc_d;
  logic           flag_d;

  assign beat_xfer = in_valid & in_ready;
  assign blk_xfer  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= G0;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      G0:      if (beat_xfer) state_d = G1;
      G1:      if (beat_xfer) state_d = G2;
      G2:      if (beat_xfer) state_d = FULL;
      FULL:    if (blk_xfer)  state_d = G0;
      default: state_d = G0;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q == FULL);
  end

  // Beat 0 uses the freshly computed width; later beats use the latched one,
  // so bitDepth/stepSize changes mid-block are invisible.
  assign raw_bits = bitDepth - stepSize;
  assign raw_bad  = (raw_bits < 4'd5) || (raw_bits > 4'd8);
  assign cur_bits = (state_q == G0) ? (raw_bad ? 4'd8 : raw_bits) : bits_q;
  assign grp      = state_q;

  // Saturate, bias and place the four samples of this beat.
  always_comb begin
    half      = 9'd1 << (cur_bits - 4'd1);
    hi_s      = $signed(half) - 9'sd1;
    lo_s      = -$signed(half);
    place     = '0;
    clamp_any = 1'b0;
    res_s     = '0;
    sat_s     = '0;
    code9     = '0;
    code_al   = '0;
    k_idx     = '0;
    shift     = '0;
    for (int j = 0; j < 4; j++) begin
      res_s = 9'($signed(in_res[31-8*j -: 8]));
      if (res_s > hi_s) begin
        sat_s     = hi_s;
        clamp_any = 1'b1;
      end else if (res_s < lo_s) begin
        sat_s     = lo_s;
        clamp_any = 1'b1;
      end else begin
        sat_s = res_s;
      end
      // Saturated value plus bias always lands in [0, 2^bits-1].
      code9   = sat_s + $signed(half);
      // Left-align the code within a byte, then shift down to its slot.
      code_al = code9[7:0] << (4'd8 - cur_bits);
      k_idx   = {4'd0, grp, 2'(j)};
      shift   = k_idx * {4'd0, cur_bits};
      place   = place | ({code_al, 120'd0} >> shift);
    end
  end

  assign acc_d  = ((state_q == G0) ? 128'd0 : acc_q) | place;
  assign flag_d = ((state_q == G0) ? raw_bad : flag_q) | clamp_any;

  // Datapath: accumulate per beat, snapshot the block on the third beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q    <= '0;
      acc_q     <= '0;
      flag_q    <= 1'b0;
      suffix    <= '0;
      qres_size <= '0;
      out_err   <= 1'b0;
    end else if (beat_xfer) begin
      bits_q <= cur_bits;
      acc_q  <= acc_d;
      flag_q <= flag_d;
      if (state_q == G2) begin
        suffix    <= acc_d;
        qres_size <= {4'd0, cur_bits} * 8'd12;
        out_err   <= flag_d;
      end
    end
  end

endmodule

// File: tb/tb_enc_mpp_suffix_pack.sv
module tb_enc_mpp_suffix_pack;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   bitDepth, stepSize;
  logic         in_valid, in_ready;
  logic [31:0]  in_res;
  logic         out_valid, out_ready;
  logic [127:0] suffix;
  logic [7:0]   qres_size;
  logic         out_err;

  always #5 clk = ~clk;

  enc_mpp_suffix_pack #(.ssm_idx(0), .comp(0)) dut (
    .clk(clk), .rst(rst), .bitDepth(bitDepth), .stepSize(stepSize),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
    .out_valid(out_valid), .out_ready(out_ready), .suffix(suffix),
    .qres_size(qres_size), .out_err(out_err)
  );

  typedef struct packed {
    logic [127:0] s;
    logic [7:0]   q;
    logic         e;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  logic signed [7:0] res_tab[12];
  logic [127:0] cap_s;
  logic [7:0]   cap_q;
  logic         cap_e;

  // Reference: width from bitDepth-stepSize, saturate, bias, then emit bits MSB-first.
  function automatic exp_t model(input int bd, input int ss);
    exp_t e;
    int b, half, r, pos;
    e = '0;
    b = (bd - ss) & 15;
    if (b < 5 || b > 8) begin
      b = 8;
      e.e = 1'b1;
    end
    half = 1 << (b - 1);
    pos = 127;
    for (int k = 0; k < 12; k++) begin
      r = res_tab[k];
      if (r > half - 1) begin r = half - 1; e.e = 1'b1; end
      else if (r < -half) begin r = -half; e.e = 1'b1; end
      r = r + half;
      for (int i = b - 1; i >= 0; i--) begin
        e.s[pos] = r[i];
        pos--;
      end
    end
    e.q = 8'(b * 12);
    return e;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready_vs_out_valid", {127'd0, in_ready}, {127'd0, !out_valid});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_block actual=out_valid_high expected=no_block_pending");
        end else begin
          check("suffix", suffix, exp_q[0].s);
          check("qres_size", {120'd0, qres_size}, {120'd0, exp_q[0].q});
          check("out_err", {127'd0, out_err}, {127'd0, exp_q[0].e});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic set_all(input int v);
    for (int k = 0; k < 12; k++) res_tab[k] = 8'(v);
  endtask

  task automatic send_beat(input int g, input int bd, input int ss);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("beat_ready_timeout", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_res = {res_tab[4*g], res_tab[4*g+1], res_tab[4*g+2], res_tab[4*g+3]};
    if (g == 0) begin
      bitDepth = 4'(bd);
      stepSize = 4'(ss);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_res = $urandom;
    if (g == 0) begin
      bitDepth = 4'($urandom);
      stepSize = 4'($urandom);
    end
  endtask

  task automatic send_block(input int bd, input int ss);
    for (int g = 0; g < 3; g++) send_beat(g, bd, ss);
    exp_q.push_back(model(bd, ss));
    @(negedge clk);
    check("latency_out_valid", {127'd0, out_valid}, 128'd1);
    cap_s = suffix;
    cap_q = qres_size;
    cap_e = out_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mix[12];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    bitDepth = 4'd8; stepSize = 4'd0; in_res = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_suffix", suffix, 128'd0);
    check("rst_qres", {120'd0, qres_size}, 128'd0);
    check("rst_err", {127'd0, out_err}, 128'd0);

    // bits=8, all zero
    set_all(0); send_block(8, 0);
    check("t1_suffix", cap_s, 128'h80808080_80808080_80808080_00000000);
    check("t1_qres", {120'd0, cap_q}, 128'd96);
    check("t1_err", {127'd0, cap_e}, 128'd0);

    // bits=5, lower bound
    set_all(-16); send_block(8, 3);
    check("t2_suffix", cap_s, 128'd0);
    check("t2_qres", {120'd0, cap_q}, 128'd60);
    check("t2_err", {127'd0, cap_e}, 128'd0);

    // bits=5, upper bound
    set_all(15); send_block(8, 3);
    check("t3_suffix", cap_s, 128'hFFFFFFFF_FFFFFFF0_00000000_00000000);

    // bits=5, first sample saturates
    set_all(0); res_tab[0] = 8'sd20; send_block(8, 3);
    check("t4_suffix", cap_s, 128'hFC210842_10842100_00000000_00000000);
    check("t4_err", {127'd0, cap_e}, 128'd1);

    // next clean block clears the error
    set_all(0); send_block(8, 3);
    check("t5_suffix", cap_s, 128'h84210842_10842100_00000000_00000000);
    check("t5_err", {127'd0, cap_e}, 128'd0);

    // illegal bits=2 falls back to 8
    set_all(0); send_block(4, 2);
    check("t6_suffix", cap_s, 128'h80808080_80808080_80808080_00000000);
    check("t6_qres", {120'd0, cap_q}, 128'd96);
    check("t6_err", {127'd0, cap_e}, 128'd1);

    // bits=7 with clamps on both sides
    mix = '{-64, 63, -100, 100, 1, -1, 5, -5, 0, 10, -20, 30};
    for (int k = 0; k < 12; k++) res_tab[k] = 8'(mix[k]);
    send_block(9, 2);
    check("t_mix_err", {127'd0, cap_e}, 128'd1);

    // bits=6 clean, varied values
    for (int k = 0; k < 12; k++) res_tab[k] = 8'(k * 5 - 30);
    send_block(15, 9);

    // bitDepth-stepSize wraps to 13 -> illegal
    for (int k = 0; k < 12; k++) res_tab[k] = 8'(k * 10 - 60);
    send_block(2, 5);
    check("t_wrap_qres", {120'd0, cap_q}, 128'd96);

    // backpressure
    @(posedge clk); #1 out_ready = 1'b0;
    for (int k = 0; k < 12; k++) res_tab[k] = 8'(k - 6);
    send_block(8, 1);
    in_valid = 1'b1; in_res = 32'h7F80_7F80;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", {127'd0, in_ready}, 128'd0);
      check("bp_suffix_stable", suffix, cap_s);
      check("bp_qres_stable", {120'd0, qres_size}, {120'd0, cap_q});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
    check("bp_release_out_valid", {127'd0, out_valid}, 128'd0);
    set_all(3); send_block(8, 2);

    // reset mid-block
    set_all(7);
    send_beat(0, 8, 2);
    send_beat(1, 8, 2);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("mid_rst_qres", {120'd0, qres_size}, 128'd0);
    set_all(0); send_block(8, 2);
    check("t7_suffix", cap_s, 128'h82082082_08208208_20000000_00000000);
    check("t7_qres", {120'd0, cap_q}, 128'd72);

    repeat (5) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enc_mpp_suffix_pack.md
# enc_mpp_suffix_pack

Encoder-side midpoint-prediction (MPP) suffix packer for one colour component of one substream. It accepts quantized MPP residuals four samples per beat, three beats per block. Each residual is offset-biased into an unsigned `bits`-wide code, where `bits = bitDepth - stepSize`. The 12 codes are packed MSB-first into a left-aligned 128-bit suffix word, which is handed to the substream bit writer together with its bit length. The word layout is exactly what the decoder-side MPP suffix parser consumes.

## Interface
Parameters:
- `ssm_idx`, 0, substream index this instance feeds (identification only, no logic effect)
- `comp`, 0, component index (identification only, no logic effect)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous and active-high
- `bitDepth`  in  4  component bit depth; sampled only on acceptance of beat 0
- `stepSize`  in  4  MPP quantizer step; sampled only on acceptance of beat 0
- `in_valid`  in  1  residual beat valid
- `in_ready`  out  1  packer can accept a beat
- `in_res`  in  32  four signed 8-bit residuals; sample j of the beat is at `[31-8j -: 8]`
- `out_valid`  out  1  packed block available
- `out_ready`  in  1  bit writer accepts the block
- `suffix`  out  128  packed codes, left-aligned, unused LSBs are 0
- `qres_size`  out  8  number of valid suffix bits, equal to `bits*12`
- `out_err`  out  1  block had a clamped residual or an illegal `bits` value

## Operation
- Beat transfer occurs when `in_valid & in_ready` are both high on a clock edge.
- Block transfer occurs when `out_valid & out_ready` are both high on a clock edge.
- FSM has four states: `G0`, `G1`, `G2`, `FULL`.
  - `G0` → `G1` → `G2` advance on each beat transfer.
  - `G2` → `FULL` on a beat transfer.
  - `FULL` → `G0` on a block transfer.
- `in_ready = (state != FULL)`, decoded combinationally from the state register.
- On the beat transfer in `G0`:
  - `bits` is latched as `bitDepth - stepSize`, computed mod 16.
  - The accumulator is cleared.
  - The sticky error flag is cleared.
- If the latched `bits` is outside 5..8:
  - `bits` is replaced by 8 for the rest of the block.
  - The error flag is set.
- Per sample, with `a = bits-1`:
  - Legal range is `[-(1<<a), (1<<a)-1]`.
  - Out-of-range residuals are saturated to the nearest bound and set the error flag.
  - `code = (res + (1<<a)) mod 2^bits`.
- Sample index `k = 4*g + j`, where g is the beat number 0..2. Code k is written to `acc[127 - k*bits -: bits]`. All other accumulator bits remain 0.
- On entering `FULL`, the following are registered and held stable until the block transfer:
  - `suffix = acc`
  - `qres_size = bits*12`, computed in 8 bits (max 96)
  - `out_err = flag`
- `out_valid = (state == FULL)`.
- Inputs presented while `in_ready = 0` are ignored.
- `bitDepth`/`stepSize` changes after beat 0 have no effect on the current block.

## Timing
- Reset values:
  - state `G0`, so `in_ready = 1` in the cycle after the reset edge
  - `out_valid = 0`, `suffix = 0`, `qres_size = 0`, `out_err = 0`
  - accumulator, `bits` and error flag all cleared
- Reset asserted mid-block discards any partial block and any held output. The block is never emitted.
- Latency: `out_valid` rises in the cycle after the edge that accepts beat 2.
- Throughput: minimum 4 cycles per block (3 beat transfers plus 1 block-transfer cycle). There is no overlap between `FULL` and the next block's beat 0.
- With `out_ready = 0`:
  - all outputs are held stable
  - `in_ready` stays 0
  - no input beat is accepted
- `out_ready` high while `out_valid` is low has no effect.
- `in_valid` gaps between beats are allowed. Partial state is held indefinitely.

## Test plan
- bitDepth=8, stepSize=0, all 12 residuals 0 → `suffix` = `0x80` repeated 12 times then 32 zero bits, `qres_size = 96`, `out_err = 0`.
- bitDepth=8, stepSize=3 (bits=5):
  - all residuals -16 → `suffix = 0`, `qres_size = 60`
  - all residuals 15 → top 60 bits all 1, low 68 bits 0
- bits=5, first residual +20, rest 0 → first code `0x1F` (saturated), remaining codes `0x10`, `out_err = 1`. The next clean block then shows `out_err = 0`.
- bitDepth=4, stepSize=2 (illegal bits=2) → block packed with bits=8, `qres_size = 96`, `out_err = 1`.
- Backpressure: hold `out_ready = 0` for 5 cycles after `out_valid` with `in_valid` high → outputs stable, `in_ready = 0`, no beat consumed. Release → `in_ready = 1` the next cycle.
- Reset asserted after beat 1, then a full new block with bits=6 sent → only the new block appears, `qres_size = 72`, codes at a 6-bit pitch.
